// File: rtl/teclado_matricial.sv
// teclado_matricial: scans a 4x4 active-low keypad, debounces presses and releases,
// and emits one ativo strobe with the key code for each physical press.
module teclado_matricial #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] linhas,
  output logic [3:0] colunas,
  output logic [4:0] tecla_atual,
  output logic       ativo,
  output logic       tecla_pressionada
);

  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SCAN_ONE  = SW'(1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [4:0]    T_NONE    = 5'd31;

  typedef enum logic [1:0] {
    VARRE         = 2'd0,
    DEBOUNCE      = 2'd1,
    EMITE         = 2'd2,
    ESPERA_SOLTAR = 2'd3
  } estado_t;

  estado_t       state_q;
  logic [3:0]    linhas_m_q;
  logic [3:0]    linhas_s_q;
  logic [1:0]    idx_q;
  logic [1:0]    row_q;
  logic [SW-1:0] div_q;
  logic [DW-1:0] deb_q;
  logic [DW-1:0] rel_q;
  logic [3:0]    colunas_q;
  logic [4:0]    tecla_q;
  logic          ativo_q;
  logic          pressionada_q;

  logic [1:0]    idx_adv_d;
  logic [3:0]    col_adv_d;
  logic [1:0]    row_hit_d;
  logic          row_low_d;
  logic          all_high_d;

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    case (idx)
      2'd0:    col_drive = 4'b1110;
      2'd1:    col_drive = 4'b1101;
      2'd2:    col_drive = 4'b1011;
      2'd3:    col_drive = 4'b0111;
      default: col_drive = 4'b1111;
    endcase
  endfunction

  // Lowest-index low row wins when several keys share the driven column.
  function automatic logic [1:0] first_low(input logic [3:0] v);
    if (!v[0]) begin
      first_low = 2'd0;
    end else if (!v[1]) begin
      first_low = 2'd1;
    end else if (!v[2]) begin
      first_low = 2'd2;
    end else begin
      first_low = 2'd3;
    end
  endfunction

  function automatic logic [4:0] key_code(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'b00_00: key_code = 5'd1;
      4'b00_01: key_code = 5'd2;
      4'b00_10: key_code = 5'd3;
      4'b00_11: key_code = 5'd10;
      4'b01_00: key_code = 5'd4;
      4'b01_01: key_code = 5'd5;
      4'b01_10: key_code = 5'd6;
      4'b01_11: key_code = 5'd11;
      4'b10_00: key_code = 5'd7;
      4'b10_01: key_code = 5'd8;
      4'b10_10: key_code = 5'd9;
      4'b10_11: key_code = 5'd12;
      4'b11_00: key_code = 5'd14;
      4'b11_01: key_code = 5'd0;
      4'b11_10: key_code = 5'd15;
      4'b11_11: key_code = 5'd13;
      default:  key_code = T_NONE;
    endcase
  endfunction

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      linhas_m_q <= 4'hF;
      linhas_s_q <= 4'hF;
    end else begin
      linhas_m_q <= linhas;
      linhas_s_q <= linhas_m_q;
    end
  end

  // Decode helpers shared by the scanner state machine.
  always_comb begin
    idx_adv_d  = idx_q + 2'd1;
    col_adv_d  = col_drive(idx_adv_d);
    row_hit_d  = first_low(linhas_s_q);
    row_low_d  = ~linhas_s_q[row_q];
    all_high_d = (linhas_s_q == 4'hF);
  end

  // Scanner state machine with registered column drive and key outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= VARRE;
      idx_q         <= 2'd0;
      row_q         <= 2'd0;
      div_q         <= '0;
      deb_q         <= '0;
      rel_q         <= '0;
      colunas_q     <= 4'b1110;
      tecla_q       <= T_NONE;
      ativo_q       <= 1'b0;
      pressionada_q <= 1'b0;
    end else begin
      ativo_q <= 1'b0;
      case (state_q)
        VARRE: begin
          if (div_q == SCAN_LAST) begin
            div_q <= '0;
            if (!all_high_d) begin
              row_q   <= row_hit_d;
              deb_q   <= '0;
              state_q <= DEBOUNCE;
            end else begin
              idx_q     <= idx_adv_d;
              colunas_q <= col_adv_d;
            end
          end else begin
            div_q <= div_q + SCAN_ONE;
          end
        end
        DEBOUNCE: begin
          if (row_low_d) begin
            if (deb_q == DEB_LAST) begin
              deb_q   <= '0;
              state_q <= EMITE;
            end else begin
              deb_q <= deb_q + DEB_ONE;
            end
          end else begin
            // A bounce drops back to scanning from the next column.
            deb_q     <= '0;
            div_q     <= '0;
            idx_q     <= idx_adv_d;
            colunas_q <= col_adv_d;
            state_q   <= VARRE;
          end
        end
        EMITE: begin
          tecla_q       <= key_code(row_q, idx_q);
          ativo_q       <= 1'b1;
          pressionada_q <= 1'b1;
          rel_q         <= '0;
          state_q       <= ESPERA_SOLTAR;
        end
        ESPERA_SOLTAR: begin
          if (all_high_d) begin
            if (rel_q == DEB_LAST) begin
              rel_q         <= '0;
              div_q         <= '0;
              idx_q         <= idx_adv_d;
              colunas_q     <= col_adv_d;
              pressionada_q <= 1'b0;
              state_q       <= VARRE;
            end else begin
              rel_q <= rel_q + DEB_ONE;
            end
          end else begin
            rel_q <= '0;
          end
        end
        default: begin
          state_q   <= VARRE;
          idx_q     <= 2'd0;
          div_q     <= '0;
          colunas_q <= 4'b1110;
        end
      endcase
    end
  end

  assign colunas           = colunas_q;
  assign tecla_atual       = tecla_q;
  assign ativo             = ativo_q;
  assign tecla_pressionada = pressionada_q;

endmodule

// File: tb/tb_teclado_matricial.sv
// Bench for teclado_matricial: a keypad model drives the rows from the column drive, and a
// cycle-level behavioural reference predicts every output, plus directed literal checks.
`timescale 1ns/1ps
module tb_teclado_matricial;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int M_SCAN = 0, M_CONF = 1, M_EMIT = 2, M_HOLD = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] keys_s;
  logic [3:0]  linhas;
  logic [3:0]  colunas;
  logic [4:0]  tecla_atual;
  logic        ativo;
  logic        tecla_pressionada;

  int n_vec = 0;
  int n_err = 0;
  int dut_pulses = 0;
  int mdl_pulses = 0;
  bit prev_ativo = 1'b0;
  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  // reference state: synchronizer history, activity, column, timers, outputs
  logic [3:0] m_hist0, m_hist1;
  int m_mode, m_col, m_dwell, m_run, m_rel, m_row, m_key;
  bit m_ativo, m_held;
  bit m_init = 1'b0;

  teclado_matricial #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYC(DEB)) dut (
    .clk               (clk),
    .reset             (reset),
    .linhas            (linhas),
    .colunas           (colunas),
    .tecla_atual       (tecla_atual),
    .ativo             (ativo),
    .tecla_pressionada (tecla_pressionada)
  );

  // key index r*4+c pulls row r low while column c is driven low
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign linhas[r] = ~|(keys_s[r*4 +: 4] & ~colunas);
  end

  always #5 clk = ~clk;

  function automatic int lowest_low(input logic [3:0] v);
    int r;
    r = 0;
    for (int b = 3; b >= 0; b--) if (!v[b]) r = b;
    return r;
  endfunction

  task automatic model_step();
    logic [3:0] ls;
    if (reset) begin
      m_hist0 = 4'hF; m_hist1 = 4'hF;
      m_mode = M_SCAN; m_col = 0; m_dwell = 0; m_run = 0; m_rel = 0; m_row = 0;
      m_key = 31; m_ativo = 1'b0; m_held = 1'b0; m_init = 1'b1;
    end else begin
      ls = m_hist1;
      m_hist1 = m_hist0;
      m_hist0 = linhas;
      m_ativo = 1'b0;
      if (m_mode == M_SCAN) begin
        if (m_dwell == SCAN_DIV - 1) begin
          m_dwell = 0;
          if (ls != 4'hF) begin
            m_row = lowest_low(ls); m_run = 0; m_mode = M_CONF;
          end else begin
            m_col = (m_col + 1) % 4;
          end
        end else begin
          m_dwell++;
        end
      end else if (m_mode == M_CONF) begin
        if (!ls[m_row]) begin
          m_run++;
          if (m_run == DEB) m_mode = M_EMIT;
        end else begin
          m_mode = M_SCAN; m_col = (m_col + 1) % 4; m_dwell = 0;
        end
      end else if (m_mode == M_EMIT) begin
        m_key = keymap[m_row*4 + m_col]; m_ativo = 1'b1; m_held = 1'b1; m_rel = 0;
        m_mode = M_HOLD;
      end else begin
        if (ls == 4'hF) begin
          m_rel++;
          if (m_rel == DEB) begin
            m_mode = M_SCAN; m_held = 1'b0; m_col = (m_col + 1) % 4; m_dwell = 0;
          end
        end else begin
          m_rel = 0;
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  task automatic check_cycle();
    logic [3:0] exp_col;
    exp_col = ~(4'b0001 << m_col);
    n_vec++;
    if (colunas !== exp_col) begin
      n_err++; $display("FAIL colunas t=%0t dut=%b model=%b", $time, colunas, exp_col);
    end
    if (tecla_atual !== 5'(m_key)) begin
      n_err++; $display("FAIL tecla_atual t=%0t dut=%0d model=%0d", $time, tecla_atual, m_key);
    end
    if (ativo !== m_ativo) begin
      n_err++; $display("FAIL ativo t=%0t dut=%b model=%b", $time, ativo, m_ativo);
    end
    if (tecla_pressionada !== m_held) begin
      n_err++; $display("FAIL pressionada t=%0t dut=%b model=%b", $time, tecla_pressionada, m_held);
    end
    if (ativo === 1'b1 && prev_ativo) begin
      n_err++; $display("FAIL ativo_double t=%0t dut=1 required=0", $time);
    end
    if (ativo === 1'b1) dut_pulses++;
    if (m_ativo) mdl_pulses++;
    prev_ativo = (ativo === 1'b1);
  endtask

  always @(negedge clk) if (m_init) check_cycle();

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++; $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_reset_values(input string tag);
    expect_eq({tag, " colunas"}, 32'(colunas), 32'(4'b1110));
    expect_eq({tag, " tecla_atual"}, 32'(tecla_atual), 32'd31);
    expect_eq({tag, " ativo"}, 32'(ativo), 32'd0);
    expect_eq({tag, " pressionada"}, 32'(tecla_pressionada), 32'd0);
  endtask

  int p0, hold, nb, k;
  logic [15:0] m;
  logic [3:0] seen;
  int t5_bits  [5] = '{12, 13, 14, 15, 3};
  int t5_codes [5] = '{14, 0, 15, 13, 10};

  initial begin
    reset = 1'b1;
    keys_s = '0;
    tick(2);
    check_reset_values("reset");
    reset = 1'b0;

    // hold '5', then release: pressionada must fall exactly 2+8 edges after release
    p0 = dut_pulses;
    keys_s = 16'd1 << 5;
    tick(60);
    expect_eq("t2 pulses", 32'(dut_pulses - p0), 32'd1);
    expect_eq("t2 code", 32'(tecla_atual), 32'd5);
    expect_eq("t2 held", 32'(tecla_pressionada), 32'd1);
    keys_s = '0;
    tick(9);
    expect_eq("t2 held_before_release_done", 32'(tecla_pressionada), 32'd1);
    tick(1);
    expect_eq("t2 released", 32'(tecla_pressionada), 32'd0);
    tick(10);

    // bouncing '9'
    p0 = dut_pulses;
    for (int i = 0; i < 8; i++) begin
      keys_s = (i % 2 == 0) ? (16'd1 << 10) : 16'd0;
      tick(3);
    end
    keys_s = 16'd1 << 10;
    tick(60);
    keys_s = '0;
    tick(20);
    expect_eq("t3 pulses", 32'(dut_pulses - p0), 32'd1);
    expect_eq("t3 code", 32'(tecla_atual), 32'd9);

    // short '3' glitch: no pulse, code retained, scanning resumes over all columns
    p0 = dut_pulses;
    keys_s = 16'd1 << 2;
    tick(5);
    keys_s = '0;
    tick(40);
    expect_eq("t4 pulses", 32'(dut_pulses - p0), 32'd0);
    expect_eq("t4 code", 32'(tecla_atual), 32'd9);
    seen = 4'h0;
    for (int i = 0; i < 16; i++) begin
      seen = seen | ~colunas;
      tick(1);
    end
    expect_eq("t4 scan_cols", 32'(seen), 32'hF);

    // bottom row and 'A'
    for (int i = 0; i < 5; i++) begin
      p0 = dut_pulses;
      keys_s = 16'd1 << t5_bits[i];
      tick(40);
      keys_s = '0;
      tick(20);
      expect_eq("t5 pulses", 32'(dut_pulses - p0), 32'd1);
      expect_eq("t5 code", 32'(tecla_atual), 32'(t5_codes[i]));
    end

    // '1' and '7' together: lowest row wins; reset while held aborts
    p0 = dut_pulses;
    keys_s = (16'd1 << 0) | (16'd1 << 8);
    tick(40);
    expect_eq("t6 pulses", 32'(dut_pulses - p0), 32'd1);
    expect_eq("t6 code", 32'(tecla_atual), 32'd1);
    reset = 1'b1;
    keys_s = '0;
    tick(1);
    check_reset_values("t6 reset");
    reset = 1'b0;
    p0 = dut_pulses;
    tick(20);
    expect_eq("t6 no_pulse", 32'(dut_pulses - p0), 32'd0);

    // random presses, chords, bounces and occasional resets against the reference
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 15);
      m = 16'd1 << k;
      if ($urandom_range(0, 3) == 0) m = m | (16'd1 << $urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) begin
        nb = $urandom_range(2, 6);
        for (int j = 0; j < nb; j++) begin
          keys_s = (j % 2 == 0) ? m : 16'd0;
          tick($urandom_range(1, 4));
        end
      end
      hold = $urandom_range(1, 40);
      keys_s = m;
      tick(hold);
      keys_s = '0;
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end
      tick($urandom_range(0, 30));
    end
    tick(20);
    expect_eq("pulse total", 32'(dut_pulses), 32'(mdl_pulses));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
